serial_demux_driver: RTL and testbench
======================================

SERIAL_DEMUX_DRIVER -- requirements
Module: serial_demux_driver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the payload width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, meaning 1 shifts bit 0 first and 0 shifts bit DATA_W-1 first.
REQ-003 The block SHALL have parameter GAP_CYC, default 1, meaning the number of enforced E-low cycles after each frame (legal range 0..15).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port in_valid  input  1  upstream offers a frame.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a frame this cycle.
REQ-008 The block SHALL have port in_data  input  DATA_W  payload to serialise.
REQ-009 The block SHALL have port in_dest  input  2  destination channel for the 1-to-4 demultiplexer.
REQ-010 The block SHALL have port Y  output  1  serial data bit to the demultiplexer data input.
REQ-011 The block SHALL have port S  output  2  channel select to the demultiplexer.
REQ-012 The block SHALL have port E  output  1  demultiplexer enable, high only while a payload bit is valid on Y.
REQ-013 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-016 All outputs except in_ready SHALL be registered; in_ready SHALL equal (state == IDLE) combinationally.
REQ-017 A frame SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_data is latched into the shift register, in_dest into S, the bit counter is cleared and the state becomes SHIFT.
REQ-018 In SHIFT, E SHALL be 1 and Y SHALL carry the current bit: bit 0 first if LSB_FIRST=1, bit DATA_W-1 first otherwise; the shift register shifts and the counter increments once per cycle.
REQ-019 Latency SHALL be: accept edge N -> first bit on Y/E in cycle N+1 -> last bit in cycle N+DATA_W.
REQ-020 After the last bit, the state SHALL go to GAP if GAP_CYC>0, or to IDLE if GAP_CYC=0.
REQ-021 GAP SHALL last exactly GAP_CYC cycles with E=0 and Y=0, then go to IDLE.
REQ-022 Frame period SHALL be DATA_W+GAP_CYC+1 cycles minimum, because acceptance only occurs in IDLE.
REQ-023 done SHALL be high for exactly one cycle, in the cycle immediately following the last bit cycle.
REQ-024 Whenever E=0, Y SHALL be 0.
REQ-025 S SHALL hold the last accepted destination, unchanged through SHIFT, GAP and IDLE until the next acceptance.
REQ-026 in_valid, in_data and in_dest SHALL be ignored while in_ready=0; in_valid held high during a frame SHALL be accepted on the first IDLE cycle.
REQ-027 in_valid SHALL have no effect in IDLE while low; in_data and in_dest may be X while in_valid=0 without affecting any output.
REQ-028 The bit counter SHALL be ceil(log2(DATA_W))+1 bits wide; the GAP counter SHALL be 4 bits wide; neither counter wraps within a frame.

Reset
REQ-029 When rst_n=0 at a rising edge, state SHALL become IDLE and Y, S, E, busy, done, the shift register and both counters SHALL become 0; in_ready SHALL read 1 from the following cycle.
REQ-030 Reset asserted mid-SHIFT or mid-GAP SHALL abort the frame with no done pulse and no further E=1 cycles.
REQ-031 A frame offered in the cycle where rst_n=0 SHALL NOT be accepted.

Verification
REQ-032 Defaults: accept in_data=8'hA5, in_dest=2 -> S=2, E=1 for 8 cycles, Y=1,0,1,0,0,1,0,1, then done=1 with E=0, then 1 GAP cycle, then in_ready=1.
REQ-033 With LSB_FIRST=0, accept 8'h81, dest=3 -> Y=1,0,0,0,0,0,0,1, S=3 throughout the frame.
REQ-034 in_valid held high with frames 8'hFF/dest 0 then 8'h00/dest 1 -> second accepted exactly 10 cycles after the first, and S changes 0->1 only at the second acceptance.
REQ-035 rst_n=0 on the 4th bit cycle of an 8'hF0 frame -> next cycle Y=E=S=busy=done=0, and no done pulse is ever seen for that frame.
REQ-036 GAP_CYC=0, DATA_W=4, back-to-back 4'h9 then 4'h6 -> frame period is 5 cycles, with done coinciding with the IDLE/accept cycle.
REQ-037 Driving in_data/in_dest to X while in_valid=0 in IDLE for 20 cycles -> no X on any output, and E stays 0.

Source files
------------

// File: rtl/serial_demux_driver.sv
// serial_demux_driver
//   Serialises a DATA_W-bit payload onto a single data line feeding a 1-to-4
//   demultiplexer. The channel select is held for the whole frame. The enable
//   is high only while a payload bit is on the data line. An optional run of
//   enforced idle (E-low) cycles follows each frame.
//
// Ports
//   clk       in   single clock, rising-edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   upstream offers a frame
//   in_ready  out  high in IDLE (combinational), frame accepted when both high
//   in_data   in   DATA_W payload
//   in_dest   in   2-bit destination channel
//   Y         out  serial data bit (0 whenever E is 0)
//   S         out  channel select, last accepted destination
//   E         out  demux enable, high for exactly DATA_W cycles per frame
//   busy      out  high whenever the FSM is not in IDLE
//   done      out  one-cycle pulse in the cycle after the last bit
module serial_demux_driver #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int GAP_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic              Y,
  output logic [1:0]        S,
  output logic              E,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              y_q, y_d;
  logic [1:0]        s_q, s_d;
  logic              e_q, e_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Payload re-ordered so that the first bit to transmit sits in bit 0; the
  // shifter then always shifts right regardless of bit order.
  logic [DATA_W-1:0] load_word;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign load_word = in_data;
    end else begin : g_msb_first
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
        assign load_word[gi] = in_data[DATA_W-1-gi];
      end
    end
  endgenerate

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    y_d       = 1'b0;
    e_d       = 1'b0;
    s_d       = s_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Y is registered, so the first bit is presented straight from the
          // load word; the register keeps the bits still to be sent.
          state_d   = SHIFT;
          shreg_d   = load_word >> 1;
          y_d       = load_word[0];
          e_d       = 1'b1;
          s_d       = in_dest;
          bit_cnt_d = '0;
        end
      end

      SHIFT: begin
        // bit_cnt_q is the index of the bit currently on Y.
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          done_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = (GAP_CYC > 0) ? GAP : IDLE;
        end else begin
          y_d     = shreg_q[0];
          e_d     = 1'b1;
          shreg_d = shreg_q >> 1;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      y_q       <= 1'b0;
      s_q       <= 2'd0;
      e_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      y_q       <= y_d;
      s_q       <= s_d;
      e_q       <= e_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Y    = y_q;
  assign S    = s_q;
  assign E    = e_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_demux_driver.sv
// Bench for serial_demux_driver: default instance checked every cycle against
// a cycles-since-accept reference model; two extra instances cover MSB-first
// ordering and the zero-gap back-to-back case.
module tb_serial_demux_driver;

  localparam int W0  = 8;
  localparam int G0  = 1;
  localparam int BIG = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  // default instance
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       y, e, busy, done;
  logic [1:0] s;

  // MSB-first instance
  logic       v1, rdy1, y1, e1, busy1, done1;
  logic [7:0] d1;
  logic [1:0] dst1, s1;

  // 4-bit, zero-gap instance
  logic       v2, rdy2, y2, e2, busy2, done2;
  logic [3:0] d2;
  logic [1:0] dst2, s2;

  serial_demux_driver dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .Y(y), .S(s), .E(e),
    .busy(busy), .done(done)
  );

  serial_demux_driver #(.DATA_W(8), .LSB_FIRST(0), .GAP_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .in_dest(dst1), .Y(y1), .S(s1), .E(e1),
    .busy(busy1), .done(done1)
  );

  serial_demux_driver #(.DATA_W(4), .LSB_FIRST(1), .GAP_CYC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .in_dest(dst2), .Y(y2), .S(s2), .E(e2),
    .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int acc_cyc = -1;

  // reference model for dut0: cycles since the accepting edge
  int         mk = BIG;
  logic [7:0] mdata = 8'h00;
  logic [1:0] ms = 2'd0;
  logic       m_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance one clock, update the model and compare.
  task automatic step0(input logic rst, input logic v, input logic [7:0] d, input logic [1:0] dst);
    logic acc;
    logic my, me, mbusy, mdone;
    rst_n    = rst;
    in_valid = v;
    in_data  = d;
    in_dest  = dst;
    acc = rst && (v === 1'b1) && m_ready;
    if (acc) begin
      acc_cyc = cyc;
      n_acc++;
      $display("frame accepted: cycle %0d data=%02h dest=%0d", cyc, d, dst);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      mk = BIG;
      ms = 2'd0;
    end else if (acc) begin
      mk    = 1;
      mdata = d;
      ms    = dst;
    end else if (mk < BIG) begin
      mk++;
    end
    me    = (mk >= 1) && (mk <= W0);
    my    = me ? mdata[mk-1] : 1'b0;
    mdone = (mk == W0 + 1);
    mbusy = (mk >= 1) && (mk <= W0 + G0);
    m_ready = !mbusy;
    chk("model", {25'd0, y, e, s, busy, done, in_ready},
        {25'd0, my, me, ms, mbusy, mdone, m_ready});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step0(1'b1, 1'b0, 8'h00, 2'd0);
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [1:0] dest;
    logic       y;
    logic       e;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t_a, t_b, base, dcnt, t1, t2;
    logic [7:0] pat;
    logic [3:0] pat2;

    // inputs -> outputs seen the cycle after
    vecs[0]  = '{1'b1, 8'hA5, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1};

    v1 = 1'b0; d1 = 8'h00; dst1 = 2'd0;
    v2 = 1'b0; d2 = 4'h0;  dst2 = 2'd0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0;
    #1;

    // reset, with a frame offered during reset that must be ignored
    step0(1'b0, 1'b0, 8'h00, 2'd0);
    step0(1'b0, 1'b1, 8'h3C, 2'd3);
    chk("reset_state", {25'd0, y, e, s, busy, done, in_ready}, 32'h1);
    chk("reset_other", {30'd0, rdy1, rdy2}, 32'h3);
    idle(2);

    // default frame A5 / dest 2
    for (int r = 0; r < 11; r++) begin
      step0(1'b1, vecs[r].valid, vecs[r].data, vecs[r].dest);
      chk($sformatf("vec%0d", r), {25'd0, y, e, s, busy, done, in_ready},
          {25'd0, vecs[r].y, vecs[r].e, vecs[r].s, vecs[r].busy, vecs[r].done, vecs[r].rdy});
    end

    // in_valid held high across two frames
    base = n_acc; t_a = -1; t_b = -1;
    for (int i = 0; i < 30 && n_acc < base + 2; i++) begin
      if (n_acc == base) step0(1'b1, 1'b1, 8'hFF, 2'd0);
      else               step0(1'b1, 1'b1, 8'h00, 2'd1);
      if (n_acc == base + 1 && t_a < 0) t_a = acc_cyc;
      if (n_acc == base + 2) t_b = acc_cyc;
      if (n_acc == base + 1) chk("s_hold_first", {30'd0, s}, 32'd0);
    end
    chk("hold_valid_period", t_b - t_a, 32'd10);
    chk("s_second", {30'd0, s}, 32'd1);
    idle(12);

    // reset on the 4th bit cycle of an F0 frame
    step0(1'b1, 1'b1, 8'hF0, 2'd2);
    idle(3);
    chk("abort_in_shift", {31'd0, e}, 32'd1);
    step0(1'b0, 1'b0, 8'h00, 2'd0);
    chk("abort_outputs", {25'd0, y, e, s, busy, done, in_ready}, 32'h1);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      idle(1);
      if (done === 1'b1 || e === 1'b1) dcnt++;
    end
    chk("abort_no_done", dcnt, 32'd0);

    // unknown data/dest while idle and not valid
    for (int i = 0; i < 20; i++) begin
      step0(1'b1, 1'b0, 8'hxx, 2'bxx);
      chk("no_x_out", {31'd0, $isunknown({y, e, s, busy, done, in_ready})}, 32'd0);
    end

    // MSB-first: 81 / dest 3
    pat = 8'h81;
    v1 = 1'b1; d1 = pat; dst1 = 2'd3;
    idle(1);
    v1 = 1'b0; d1 = 8'h00; dst1 = 2'd0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("msb_bit%0d", i), {29'd0, y1, s1}, {29'd0, pat[7-i], 2'd3});
      chk("msb_e", {31'd0, e1}, 32'd1);
      idle(1);
    end
    chk("msb_done", {28'd0, y1, e1, done1, busy1}, 32'h3);
    chk("msb_s_after", {30'd0, s1}, 32'd3);
    $display("frame msb-first 81 dest 3 complete at cycle %0d", cyc);
    idle(3);

    // 4-bit, no gap: 9 then 6 back to back
    v2 = 1'b1; d2 = 4'h9; dst2 = 2'd0;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 16 && t2 < 0; i++) begin
      if (v2 && rdy2) begin
        if (t1 < 0) begin
          t1 = cyc;
        end else begin
          t2 = cyc;
          chk("gap0_done_at_accept", {31'd0, done2}, 32'd1);
        end
      end
      idle(1);
      if (t1 >= 0 && t2 < 0 && d2 == 4'h9) begin
        d2 = 4'h6; dst2 = 2'd1;
      end
      if (t1 >= 0 && t2 < 0 && (cyc - t1) >= 1 && (cyc - t1) <= 4) begin
        pat2 = 4'h9;
        chk("gap0_bit_first", {30'd0, y2, e2}, {30'd0, pat2[cyc-t1-1], 1'b1});
      end
    end
    v2 = 1'b0;
    chk("gap0_period", t2 - t1, 32'd5);
    pat2 = 4'h6;
    for (int i = 0; i < 4; i++) begin
      chk("gap0_bit_second", {29'd0, y2, e2, s2[0]}, {29'd0, pat2[i], 1'b1, 1'b1});
      idle(1);
    end
    chk("gap0_done2", {29'd0, done2, e2, rdy2}, 32'h5);
    $display("frames 4-bit 9/6 accepted at cycles %0d and %0d", t1, t2);

    // randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      step0(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
            8'($urandom), 2'($urandom));
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
